// File: rtl/sel8_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin selector arbiter.
package sel8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

endpackage

// File: rtl/sel8_rr_arbiter_pick.sv
// Combinational rotating priority pick: first set bit of vec scanning start, start+1, ... modulo 8.
module rr_pick8
  import sel8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Walk the offsets backwards so the last hit written is the one nearest to start.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel8_rr_arbiter.sv
// Round-robin arbiter sharing the 8:1 selector; hold limit stops one owner monopolising it.
module sel8_rr_arbiter
  import sel8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             gnt_valid
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic [N_REQ-1:0] gnt_q;
  logic [IDX_W-1:0] sel_q;
  logic             valid_q;

  logic [N_REQ-1:0] maskedReq;
  logic [IDX_W-1:0] idleIdx;
  logic             idleFound;
  logic [IDX_W-1:0] maskIdx;
  logic             maskFound;
  logic             atLimit;

  // The masked pick excludes the current owner so a handover never re-selects it.
  assign maskedReq = req & ~(N_REQ'(1) << sel_q);

  rr_pick8 u_pickIdle (
    .vec   (req),
    .start (ptr_q),
    .idx   (idleIdx),
    .found (idleFound)
  );

  rr_pick8 u_pickMask (
    .vec   (maskedReq),
    .start (ptr_q),
    .idx   (maskIdx),
    .found (maskFound)
  );

  assign atLimit = (hold_q >= CNT_W'(MAX_HOLD));
  assign hold_d  = atLimit ? hold_q : hold_q + CNT_W'(1);

  // Release takes precedence over preemption; both advance ptr past the old owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idleFound) begin
            state_q <= ST_GRANT;
            gnt_q   <= N_REQ'(1) << idleIdx;
            sel_q   <= idleIdx;
            valid_q <= 1'b1;
            hold_q  <= CNT_W'(1);
          end else begin
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (!req[sel_q]) begin
            ptr_q <= sel_q + IDX_W'(1);
            if (maskFound) begin
              gnt_q  <= N_REQ'(1) << maskIdx;
              sel_q  <= maskIdx;
              hold_q <= CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
              sel_q   <= '0;
              valid_q <= 1'b0;
              hold_q  <= '0;
            end
          end else if (atLimit && maskFound) begin
            ptr_q  <= sel_q + IDX_W'(1);
            gnt_q  <= N_REQ'(1) << maskIdx;
            sel_q  <= maskIdx;
            hold_q <= CNT_W'(1);
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_sel8_rr_arbiter.sv
// Scoreboard bench for sel8_rr_arbiter: a behavioural model predicts each cycle's outputs.
module tb_sel8_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    int         hold;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] mGnt;
  logic [2:0] mSel;
  logic       mValid;
  logic [2:0] mPtr;
  int         mHold;

  sel8_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void mPick(input logic [7:0] v, input logic [2:0] p,
                                output logic f, output logic [2:0] ix);
    logic [2:0] c;
    f  = 1'b0;
    ix = 3'd0;
    for (int k = 0; k < 8; k++) begin
      c = p + 3'(k);
      if (!f && v[c]) begin
        f  = 1'b1;
        ix = c;
      end
    end
  endfunction

  // Advance the reference model by one clock edge using the sampled inputs.
  function automatic void modelStep(input logic [7:0] r, input logic rr);
    logic       f;
    logic [2:0] ix;
    logic [7:0] m;
    if (rr) begin
      mGnt = 8'h00; mSel = 3'd0; mValid = 1'b0; mPtr = 3'd0; mHold = 0;
    end else if (!mValid) begin
      mPick(r, mPtr, f, ix);
      if (f) begin
        mGnt = 8'h01 << ix; mSel = ix; mValid = 1'b1; mHold = 1;
      end else begin
        mHold = 0;
      end
    end else begin
      m = r;
      m[mSel] = 1'b0;
      mPick(m, mPtr, f, ix);
      if (!r[mSel]) begin
        mPtr = mSel + 3'd1;
        if (f) begin
          mGnt = 8'h01 << ix; mSel = ix; mHold = 1;
        end else begin
          mGnt = 8'h00; mSel = 3'd0; mValid = 1'b0; mHold = 0;
        end
      end else if (mHold >= MAXH && f) begin
        mPtr = mSel + 3'd1;
        mGnt = 8'h01 << ix; mSel = ix; mHold = 1;
      end else if (mHold < MAXH) begin
        mHold = mHold + 1;
      end
    end
  endfunction

  task automatic driveCycle(input logic [7:0] r, input logic rr);
    exp_t x;
    @(negedge clk);
    req = r;
    rst = rr;
    modelStep(r, rr);
    x.gnt = mGnt; x.sel = mSel; x.valid = mValid; x.hold = mHold;
    expQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      driveCycle(8'hFF, 1'b1);
      e = expQ.pop_front();
      checkCount++;
      if ({gnt, sel, gnt_valid} !== 12'h000)
        $display("[TB] FAIL reset_hold cyc%0d: got gnt=%h sel=%0d v=%b, need all zero", i, gnt, sel, gnt_valid);
      else passCount++;
    end
    driveCycle(8'hFF, 1'b0);
    e = expQ.pop_front();
    checkCount++;
    if ({gnt, sel, gnt_valid} !== {e.gnt, e.sel, e.valid} || gnt !== 8'h01)
      $display("[TB] FAIL reset_first_grant: got gnt=%h sel=%0d v=%b, need gnt=01 sel=0 v=1", gnt, sel, gnt_valid);
    else passCount++;
  endtask

  task automatic test_single();
    logic [7:0] pat [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    driveCycle(8'h00, 1'b1);
    void'(expQ.pop_front());
    for (int i = 0; i < 6; i++) begin
      driveCycle(pat[i], 1'b0);
      e = expQ.pop_front();
      checkCount++;
      if ({gnt, sel, gnt_valid} !== {e.gnt, e.sel, e.valid})
        $display("[TB] FAIL single cyc%0d: got gnt=%h sel=%0d v=%b, need gnt=%h sel=%0d v=%b",
                 i, gnt, sel, gnt_valid, e.gnt, e.sel, e.valid);
      else passCount++;
    end
  endtask

  task automatic test_rotation();
    logic [2:0] own;
    driveCycle(8'h00, 1'b1);
    void'(expQ.pop_front());
    for (int k = 0; k < 36; k++) begin
      driveCycle(8'hFF, 1'b0);
      e = expQ.pop_front();
      own = 3'((k / MAXH) % 8);
      checkCount++;
      if ({gnt, sel, gnt_valid} !== {e.gnt, e.sel, e.valid} || sel !== own || gnt !== (8'h01 << own))
        $display("[TB] FAIL rotation cyc%0d: got gnt=%h sel=%0d, need gnt=%h sel=%0d",
                 k, gnt, sel, 8'h01 << own, own);
      else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [5] = '{8'h40, 8'h48, 8'h48, 8'h08, 8'h08};
    driveCycle(8'h00, 1'b1);
    void'(expQ.pop_front());
    for (int i = 0; i < 5; i++) begin
      driveCycle(pat[i], 1'b0);
      e = expQ.pop_front();
      checkCount++;
      if ({gnt, sel, gnt_valid} !== {e.gnt, e.sel, e.valid} || gnt_valid !== 1'b1)
        $display("[TB] FAIL back_to_back cyc%0d: got gnt=%h sel=%0d v=%b, need gnt=%h sel=%0d v=1",
                 i, gnt, sel, gnt_valid, e.gnt, e.sel);
      else passCount++;
    end
    checkCount++;
    if (gnt !== 8'h08 || sel !== 3'd3)
      $display("[TB] FAIL handover_to_3: got gnt=%h sel=%0d, need gnt=08 sel=3", gnt, sel);
    else passCount++;
  endtask

  task automatic test_sole();
    driveCycle(8'h00, 1'b1);
    void'(expQ.pop_front());
    for (int k = 0; k < 12; k++) begin
      driveCycle(8'h04, 1'b0);
      e = expQ.pop_front();
      checkCount++;
      if (gnt !== 8'h04 || sel !== 3'd2 || int'(dut.hold_q) !== ((k + 1 < MAXH) ? k + 1 : MAXH))
        $display("[TB] FAIL sole cyc%0d: got gnt=%h hold=%0d, need gnt=04 hold=%0d",
                 k, gnt, dut.hold_q, (k + 1 < MAXH) ? k + 1 : MAXH);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    driveCycle(8'h00, 1'b1);
    void'(expQ.pop_front());
    driveCycle(8'h20, 1'b0);
    void'(expQ.pop_front());
    driveCycle(8'hA1, 1'b0);
    e = expQ.pop_front();
    checkCount++;
    if (sel !== 3'd5 || gnt !== 8'h20)
      $display("[TB] FAIL mid_owner5: got gnt=%h sel=%0d, need gnt=20 sel=5", gnt, sel);
    else passCount++;
    driveCycle(8'hA1, 1'b1);
    e = expQ.pop_front();
    checkCount++;
    if ({gnt, sel, gnt_valid} !== 12'h000)
      $display("[TB] FAIL mid_reset: got gnt=%h sel=%0d v=%b, need all zero", gnt, sel, gnt_valid);
    else passCount++;
    driveCycle(8'h81, 1'b0);
    e = expQ.pop_front();
    checkCount++;
    if (gnt !== 8'h01 || sel !== 3'd0 || gnt_valid !== 1'b1)
      $display("[TB] FAIL mid_regrant: got gnt=%h sel=%0d v=%b, need gnt=01 sel=0 v=1", gnt, sel, gnt_valid);
    else passCount++;
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int i = 0; i < 300; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      driveCycle(r, ($urandom_range(0, 99) == 0));
      e = expQ.pop_front();
      checkCount++;
      if ({gnt, sel, gnt_valid} !== {e.gnt, e.sel, e.valid} || $countones(gnt) > 1)
        $display("[TB] FAIL random cyc%0d: got gnt=%h sel=%0d v=%b, need gnt=%h sel=%0d v=%b",
                 i, gnt, sel, gnt_valid, e.gnt, e.sel, e.valid);
      else passCount++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    mGnt = 8'h00; mSel = 3'd0; mValid = 1'b0; mPtr = 3'd0; mHold = 0;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_sole();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
